// File: rtl/hilo_muldiv_sequencer_pkg.sv
// Shared funct codes and sequencer state encoding for the EX-stage HI/LO unit.
package hilo_muldiv_sequencer_pkg;

  // ALU funct codes decoded elsewhere in EX.
  localparam logic [5:0] FnAdd   = 6'b100000;
  localparam logic [5:0] FnAddu  = 6'b100001;
  localparam logic [5:0] FnSub   = 6'b100010;
  localparam logic [5:0] FnSubu  = 6'b100011;
  localparam logic [5:0] FnAnd   = 6'b100100;
  localparam logic [5:0] FnOr    = 6'b100101;

  localparam logic [5:0] FnMfhi  = 6'b010000;
  localparam logic [5:0] FnMthi  = 6'b010001;
  localparam logic [5:0] FnMflo  = 6'b010010;
  localparam logic [5:0] FnMtlo  = 6'b010011;
  localparam logic [5:0] FnMult  = 6'b011000;
  localparam logic [5:0] FnMultu = 6'b011001;
  localparam logic [5:0] FnDiv   = 6'b011010;
  localparam logic [5:0] FnDivu  = 6'b011011;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StFix
  } state_e;

  function automatic logic is_hilo_fn(input logic [5:0] fn);
    return fn inside {FnMfhi, FnMthi, FnMflo, FnMtlo, FnMult, FnMultu, FnDiv, FnDivu};
  endfunction

endpackage

// File: rtl/hilo_muldiv_sequencer_if.sv
// EX-stage request/response bundle between the pipeline and the HI/LO sequencer.
interface hilo_muldiv_sequencer_if #(
  parameter int unsigned NBITS  = 32,
  parameter int unsigned ANBITS = 6
);
  logic              start;
  logic [ANBITS-1:0] funct;
  logic [NBITS-1:0]  rs;
  logic [NBITS-1:0]  rt;
  logic              abort;
  logic              stall;
  logic              busy;
  logic              done;
  logic [NBITS-1:0]  result;
  logic [NBITS-1:0]  hi;
  logic [NBITS-1:0]  lo;

  modport master (
    output start, funct, rs, rt, abort,
    input  stall, busy, done, result, hi, lo
  );

  modport slave (
    input  start, funct, rs, rt, abort,
    output stall, busy, done, result, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv_sequencer_muldiv_datapath.sv
// Iterative shift-add multiplier / restoring divider on unsigned magnitudes,
// with sign correction applied combinationally to the final accumulator.
module hilo_muldiv_sequencer_muldiv_datapath #(
  parameter int unsigned NBITS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [NBITS-1:0] rs,
  input  logic [NBITS-1:0] rt,
  output logic [NBITS-1:0] hi_res,
  output logic [NBITS-1:0] lo_res
);
  localparam int unsigned W = 2 * NBITS;

  logic [W-1:0]     acc_q, acc_d;
  logic [NBITS-1:0] opnd_q;
  logic             is_div_q, neg_lo_q, neg_hi_q, div_zero_q;

  logic             rs_neg, rt_neg;
  logic [NBITS-1:0] rs_mag, rt_mag;
  logic [NBITS:0]   add_a;
  logic [NBITS+1:0] sum;
  logic             nonneg;
  logic [W-1:0]     prod;
  logic [NBITS-1:0] quo, rem;

  assign rs_neg = is_signed & rs[NBITS-1];
  assign rt_neg = is_signed & rt[NBITS-1];
  assign rs_mag = rs_neg ? -rs : rs;
  assign rt_mag = rt_neg ? -rt : rt;

  // Divide shifts the remainder left first, so the trial operand includes the next dividend bit.
  assign add_a  = is_div_q ? acc_q[W-1:NBITS-1] : {1'b0, acc_q[W-1:NBITS]};
  assign sum    = is_div_q ? ({1'b0, add_a} - {2'b00, opnd_q})
                           : ({1'b0, add_a} + {2'b00, opnd_q});
  assign nonneg = ~sum[NBITS+1];

  always_comb begin
    acc_d = acc_q;
    if (is_div_q) begin
      acc_d = {(nonneg ? sum[NBITS-1:0] : add_a[NBITS-1:0]), acc_q[NBITS-2:0], nonneg};
    end else begin
      acc_d = {(acc_q[0] ? sum[NBITS:0] : add_a), acc_q[NBITS-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      div_zero_q <= 1'b0;
    end else if (load) begin
      acc_q      <= {{NBITS{1'b0}}, (is_div ? rs_mag : rt_mag)};
      opnd_q     <= is_div ? rt_mag : rs_mag;
      is_div_q   <= is_div;
      neg_lo_q   <= rs_neg ^ rt_neg;
      neg_hi_q   <= is_div ? rs_neg : (rs_neg ^ rt_neg);
      div_zero_q <= (rt == '0);
    end else if (step) begin
      acc_q <= acc_d;
    end
  end

  assign prod = neg_lo_q ? -acc_q : acc_q;
  assign quo  = acc_q[NBITS-1:0];
  assign rem  = acc_q[W-1:NBITS];

  // A zero divisor leaves an all-ones quotient that must not be sign-corrected.
  assign hi_res = is_div_q ? (neg_hi_q ? -rem : rem) : prod[W-1:NBITS];
  assign lo_res = is_div_q ? ((neg_lo_q && !div_zero_q) ? -quo : quo) : prod[NBITS-1:0];

endmodule

// File: rtl/hilo_muldiv_sequencer.sv
// HI/LO sequencer: FSM, iteration counter, HI/LO registers and EX stall generation
// around the iterative multiply/divide datapath.
module hilo_muldiv_sequencer
  import hilo_muldiv_sequencer_pkg::*;
#(
  parameter int unsigned NBITS   = 32,
  parameter int unsigned ANBITS  = 6,
  parameter int unsigned CNTBITS = 6
) (
  input logic                   clk,
  input logic                   rst_n,
  hilo_muldiv_sequencer_if.slave bus
);
  state_e             state_q, state_d;
  logic [CNTBITS-1:0] cnt_q, cnt_d;
  logic [NBITS-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;

  logic [ANBITS-1:0]  funct;
  logic [5:0]         fn;
  logic               op_mul, op_div, op_signed, idle, last_iter;
  logic               dp_load, dp_step;
  logic [NBITS-1:0]   dp_hi, dp_lo;

  assign funct     = bus.funct;
  assign fn        = funct[5:0];
  assign op_mul    = (fn == FnMult) || (fn == FnMultu);
  assign op_div    = (fn == FnDiv) || (fn == FnDivu);
  assign op_signed = (fn == FnMult) || (fn == FnDiv);
  assign idle      = (state_q == StIdle);
  assign last_iter = (cnt_q == CNTBITS'(NBITS - 1));

  hilo_muldiv_sequencer_muldiv_datapath #(
    .NBITS(NBITS)
  ) u_datapath (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (dp_load),
    .step     (dp_step),
    .is_div   (op_div),
    .is_signed(op_signed),
    .rs       (bus.rs),
    .rt       (bus.rt),
    .hi_res   (dp_hi),
    .lo_res   (dp_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start && op_mul) begin
            state_d = StMul;
          end else if (bus.start && op_div) begin
            state_d = StDiv;
          end
        end
        StMul, StDiv: if (last_iter) state_d = StFix;
        StFix:        state_d = StIdle;
        default:      state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dp_load = 1'b0;
    dp_step = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.abort) begin
          if (op_mul || op_div) begin
            dp_load = 1'b1;
            cnt_d   = '0;
          end else if (fn == FnMthi) begin
            hi_d = bus.rs;
          end else if (fn == FnMtlo) begin
            lo_d = bus.rs;
          end
        end
      end
      StMul, StDiv: begin
        dp_step = !bus.abort;
        cnt_d   = bus.abort ? '0 : cnt_q + CNTBITS'(1);
      end
      StFix: begin
        if (!bus.abort) begin
          hi_d   = dp_hi;
          lo_d   = dp_lo;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    bus.result = '0;
    if (idle && bus.start) begin
      if (fn == FnMfhi) begin
        bus.result = hi_q;
      end else if (fn == FnMflo) begin
        bus.result = lo_q;
      end
    end
  end

  assign bus.busy  = !idle;
  assign bus.stall = bus.start && !idle && is_hilo_fn(fn);
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Randomized scoreboard bench for the HI/LO sequencer against a 64-bit arithmetic model.
module tb_hilo_muldiv_sequencer;
  import hilo_muldiv_sequencer_pkg::*;

  localparam int unsigned NBITS   = 32;
  localparam int unsigned ANBITS  = 6;
  localparam int unsigned CNTBITS = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  hilo_muldiv_sequencer_if #(.NBITS(NBITS), .ANBITS(ANBITS)) bus ();

  hilo_muldiv_sequencer #(
    .NBITS  (NBITS),
    .ANBITS (ANBITS),
    .CNTBITS(CNTBITS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_mf;
    logic [31:0] a;
    logic [31:0] b;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] t_hi, t_lo, ra, rb;
  logic [5:0]  fns[8] = '{FnMfhi, FnMthi, FnMflo, FnMtlo, FnMult, FnMultu, FnDiv, FnDivu};
  int          stalls, dones;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void model(input logic [5:0] fn, input logic [31:0] rs,
                                input logic [31:0] rt, output logic [31:0] hi,
                                output logic [31:0] lo);
    longint      a, b;
    logic [63:0] p;
    hi = m_hi;
    lo = m_lo;
    a  = longint'($signed(rs));
    b  = longint'($signed(rt));
    case (fn)
      FnMult:  begin p = 64'(a * b); hi = p[63:32]; lo = p[31:0]; end
      FnMultu: begin p = {32'h0, rs} * {32'h0, rt}; hi = p[63:32]; lo = p[31:0]; end
      FnDiv: begin
        if (rt == 32'h0) begin
          lo = '1; hi = rs;
        end else begin
          p = 64'(a / b); lo = p[31:0];
          p = 64'(a % b); hi = p[31:0];
        end
      end
      FnDivu: begin
        if (rt == 32'h0) begin
          lo = '1; hi = rs;
        end else begin
          lo = rs / rt; hi = rs % rt;
        end
      end
      FnMthi:  hi = rs;
      FnMtlo:  lo = rs;
      default: ;
    endcase
  endfunction

  task automatic issue(input logic [5:0] fn, input logic [31:0] rs, input logic [31:0] rt);
    bus.start = 1'b1;
    bus.funct = fn;
    bus.rs    = rs;
    bus.rt    = rt;
  endtask

  task automatic predict(input logic [5:0] fn, input logic [31:0] rs, input logic [31:0] rt,
                         input string name);
    logic [31:0] eh, el;
    model(fn, rs, rt, eh, el);
    if (fn inside {FnMult, FnMultu, FnDiv, FnDivu}) sb_q.push_back('{1'b0, eh, el, name});
    else if (fn == FnMfhi) sb_q.push_back('{1'b1, m_hi, 32'h0, name});
    else if (fn == FnMflo) sb_q.push_back('{1'b1, m_lo, 32'h0, name});
    m_hi = eh;
    m_lo = el;
  endtask

  // Present one instruction for a single edge, then wait (bounded) for the unit to go idle.
  task automatic run_op(input logic [5:0] fn, input logic [31:0] rs, input logic [31:0] rt,
                        input string name);
    int k;
    predict(fn, rs, rt, name);
    issue(fn, rs, rt);
    @(posedge clk);
    #1 bus.start = 1'b0;
    k = 0;
    while (bus.busy && k < 40) begin
      @(posedge clk);
      #1 k++;
    end
    check({name, " idle"}, 64'(bus.busy), 64'(0));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no pending op");
        end else begin
          mon_e = sb_q.pop_front();
          check({mon_e.name, " hi"}, 64'(bus.hi), 64'(mon_e.a));
          check({mon_e.name, " lo"}, 64'(bus.lo), 64'(mon_e.b));
        end
      end
      if (bus.start && !bus.stall && !bus.busy && (bus.funct == FnMfhi || bus.funct == FnMflo))
      begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_mf: got result=%h expected no pending read", bus.result);
        end else begin
          mon_e = sb_q.pop_front();
          check({mon_e.name, " result"}, 64'(bus.result), 64'(mon_e.a));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.funct = '0;
    bus.rs    = '0;
    bus.rt    = '0;
    #12;
    check("rst busy", 64'(bus.busy), 64'(0));
    check("rst done", 64'(bus.done), 64'(0));
    check("rst stall", 64'(bus.stall), 64'(0));
    check("rst result", 64'(bus.result), 64'(0));
    check("rst hi", 64'(bus.hi), 64'(0));
    check("rst lo", 64'(bus.lo), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full-width MULTU with cycle-exact busy/done timing.
    predict(FnMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    issue(FnMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int k = 0; k <= 34; k++) begin
      @(negedge clk);
      check($sformatf("busy_e%0d", k), 64'(bus.busy), 64'(k <= 32));
      check($sformatf("done_e%0d", k), 64'(bus.done), 64'(k == 33));
      @(posedge clk);
      #1;
    end

    run_op(FnMult, 32'hFFFF_FFFD, 32'd7, "mult_neg3x7");
    run_op(FnDiv, 32'hFFFF_FFF9, 32'd2, "div_neg7by2");
    run_op(FnDivu, 32'd7, 32'd0, "divu_7by0");
    run_op(FnDiv, 32'h8000_0000, 32'hFFFF_FFFF, "div_minint");
    run_op(FnDiv, 32'hFFFF_FFFB, 32'd0, "div_neg5by0");
    run_op(FnDiv, 32'd100, 32'hFFFF_FFF9, "div_100byneg7");
    run_op(FnAdd, 32'h1111_1111, 32'h2222_2222, "ignored_add");
    run_op(FnMfhi, 32'h0, 32'h0, "mfhi_after_add");

    // MFHI held behind an in-flight MULT.
    ra = $urandom;
    rb = $urandom;
    predict(FnMult, ra, rb, "mult_for_stall");
    issue(FnMult, ra, rb);
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    predict(FnMfhi, 32'h0, 32'h0, "mfhi_stalled");
    issue(FnMfhi, 32'h0, 32'h0);
    stalls = 0;
    while (bus.busy && stalls < 60) begin
      @(negedge clk);
      check("stall_busy", 64'(bus.stall), 64'(1));
      stalls++;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("stall_idle", 64'(bus.stall), 64'(0));
    @(posedge clk);
    #1 bus.start = 1'b0;
    check("stall_cycles", 64'(stalls), 64'(29));

    // MTLO then MFLO: single-cycle, never busy.
    issue(FnMtlo, 32'hCAFE_BABE, 32'h0);
    predict(FnMtlo, 32'hCAFE_BABE, 32'h0, "mtlo");
    @(negedge clk);
    check("mtlo stall", 64'(bus.stall), 64'(0));
    check("mtlo busy", 64'(bus.busy), 64'(0));
    @(posedge clk);
    #1;
    predict(FnMflo, 32'h0, 32'h0, "mflo_cafe");
    issue(FnMflo, 32'h0, 32'h0);
    @(negedge clk);
    check("mflo stall", 64'(bus.stall), 64'(0));
    check("mflo busy", 64'(bus.busy), 64'(0));
    check("mflo lo", 64'(bus.lo), 64'(32'hCAFE_BABE));
    @(posedge clk);
    #1 bus.start = 1'b0;

    // Abort at MULT iteration 10.
    run_op(FnMthi, 32'h1234, 32'h0, "mthi_1234");
    run_op(FnMtlo, 32'h5678, 32'h0, "mtlo_5678");
    issue(FnMult, $urandom, $urandom);
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    check("abort busy", 64'(bus.busy), 64'(0));
    check("abort hi", 64'(bus.hi), 64'(32'h1234));
    check("abort lo", 64'(bus.lo), 64'(32'h5678));
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("abort no_done", 64'(dones), 64'(0));
    @(posedge clk);
    #1;
    issue(FnDiv, 32'd9, 32'd2);
    bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.abort = 1'b0;
    check("abort_vs_start busy", 64'(bus.busy), 64'(0));

    // Asynchronous reset at DIV iteration 10.
    run_op(FnMthi, 32'hAAAA_5555, 32'h0, "mthi_pre_rst");
    issue(FnDiv, $urandom, 32'd3);
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    issue(FnMfhi, 32'h0, 32'h0);
    #1;
    check("pre_rst busy", 64'(bus.busy), 64'(1));
    check("pre_rst stall", 64'(bus.stall), 64'(1));
    rst_n = 1'b0;
    #1;
    check("async_rst busy", 64'(bus.busy), 64'(0));
    check("async_rst stall", 64'(bus.stall), 64'(0));
    check("async_rst result", 64'(bus.result), 64'(0));
    check("async_rst hi", 64'(bus.hi), 64'(0));
    check("async_rst lo", 64'(bus.lo), 64'(0));
    check("async_rst done", 64'(bus.done), 64'(0));
    m_hi = '0;
    m_lo = '0;
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op(FnMflo, 32'h0, 32'h0, "mflo_after_rst");

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(3) == 0) rb = 32'($urandom_range(7));
      if ($urandom_range(3) == 0) ra = 32'($urandom_range(100));
      run_op(fns[$urandom_range(7)], ra, rb, $sformatf("rand%0d", i));
    end
    run_op(FnMfhi, 32'h0, 32'h0, "final_mfhi");
    run_op(FnMflo, 32'h0, 32'h0, "final_mflo");

    repeat (3) @(posedge clk);
    check("scoreboard drained", 64'(sb_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
